// File: rtl/hmmm_pkg.sv
// Shared types and field positions for the hmmm_core processor.
package hmmm_pkg;

    localparam int INSTR_W = 16;
    localparam int FIELD_W = 4;
    localparam int OP_LSB  = 12;
    localparam int RX_LSB  = 8;
    localparam int RY_LSB  = 4;
    localparam int RZ_LSB  = 0;
    localparam int IMM_W   = 8;

    typedef enum logic [3:0] {
        OP_HALT   = 4'h0,
        OP_SETN   = 4'h1,
        OP_LOADR  = 4'h2,
        OP_STORER = 4'h3,
        OP_ADD    = 4'h4,
        OP_SUB    = 4'h5,
        OP_MUL    = 4'h6,
        OP_ADDN   = 4'h7,
        OP_JUMPN  = 4'h8,
        OP_JUMPR  = 4'h9,
        OP_JEQZN  = 4'hA,
        OP_JNEZN  = 4'hB,
        OP_JGTZN  = 4'hC,
        OP_JLTZN  = 4'hD,
        OP_CALLN  = 4'hE,
        OP_NOP    = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_e;

    // Three-register ALU ops read rY and rZ; everything else needs rX on port B.
    function automatic logic uses_rz(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_MUL};
    endfunction

    // Ops that write rX at the end of EXEC (loadr writes in MEM instead).
    function automatic logic writes_rx(input opcode_e op);
        return op inside {OP_SETN, OP_ADD, OP_SUB, OP_MUL, OP_ADDN, OP_CALLN};
    endfunction

endpackage

// File: rtl/hmmm_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// r0 hardwired to zero.
module hmmm_regfile #(
    parameter  int DATA_W = 8,
    parameter  int NREGS  = 8,
    localparam int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [NREGS];

    // Storage update; writes aimed at r0 are dropped so it stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/hmmm_core.sv
// hmmm_core: multi-cycle HMMM processor with a single stallable memory port.
//
// state | meaning
// FETCH | request instruction at PC, latch IR when memory is ready
// EXEC  | decode/execute; ALU, branch, call and nop retire here
// MEM   | loadr/storer data access at address rY, retires on ready
// HALT  | terminal, no requests; only reset leaves
module hmmm_core
    import hmmm_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int NREGS  = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ready,
    output logic               instr_done,
    output logic               halted
);

    localparam int IDX_W = $clog2(NREGS);

    state_e              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt, pc_inc, pc_exec;
    logic [ADDR_W-1:0]   imm_addr;
    logic [INSTR_W-1:0]  ir, ir_nxt;
    opcode_e             op;

    logic [IDX_W-1:0]    rx_idx, ry_idx, rz_idx, raddr_b;
    logic [DATA_W-1:0]   rd_a, rd_b;
    logic [DATA_W-1:0]   imm_data, alu_res;
    logic                br_taken;

    logic                rf_we;
    logic [DATA_W-1:0]   rf_wdata;
    logic                req_int;
    logic                unused_ir;

    assign op       = opcode_e'(ir[OP_LSB +: FIELD_W]);
    assign rx_idx   = ir[RX_LSB +: IDX_W];
    assign ry_idx   = ir[RY_LSB +: IDX_W];
    assign rz_idx   = ir[RZ_LSB +: IDX_W];
    // Register fields are wider than the index when NREGS < 16; upper bits are ignored.
    assign unused_ir = ^ir;

    assign pc_inc   = pc + ADDR_W'(1);
    assign imm_addr = ADDR_W'(ir[IMM_W-1:0]);
    assign imm_data = DATA_W'($signed(ir[IMM_W-1:0]));

    // Port A always carries rY. Port B carries rZ for three-register ALU ops
    // and rX otherwise (setn/addn/branches/jumpr/calln/loadr/storer).
    assign raddr_b = uses_rz(op) ? rz_idx : rx_idx;

    hmmm_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (ry_idx),
        .rdata_a (rd_a),
        .raddr_b (raddr_b),
        .rdata_b (rd_b),
        .we      (rf_we),
        .waddr   (rx_idx),
        .wdata   (rf_wdata)
    );

    // ALU result for every op that writes rX in EXEC.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_SETN:  alu_res = imm_data;
            OP_ADD:   alu_res = rd_a + rd_b;
            OP_SUB:   alu_res = rd_a - rd_b;
            OP_MUL:   alu_res = rd_a * rd_b;
            OP_ADDN:  alu_res = rd_b + imm_data;
            OP_CALLN: alu_res = DATA_W'(pc_inc);
            default:  alu_res = '0;
        endcase
    end

    // Branch condition on rX and the PC that EXEC hands to the next fetch.
    always_comb begin
        br_taken = 1'b0;
        case (op)
            OP_JEQZN: br_taken = (rd_b == '0);
            OP_JNEZN: br_taken = (rd_b != '0);
            OP_JGTZN: br_taken = !rd_b[DATA_W-1] && (rd_b != '0);
            OP_JLTZN: br_taken = rd_b[DATA_W-1];
            default:  br_taken = 1'b0;
        endcase

        pc_exec = pc_inc;
        case (op)
            OP_JUMPN, OP_CALLN:                    pc_exec = imm_addr;
            OP_JUMPR:                              pc_exec = ADDR_W'(rd_b);
            OP_JEQZN, OP_JNEZN, OP_JGTZN, OP_JLTZN: pc_exec = br_taken ? imm_addr : pc_inc;
            default:                               pc_exec = pc_inc;
        endcase
    end

    // Next-state, register write control and memory port drive.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ir_nxt     = ir;
        rf_we      = 1'b0;
        rf_wdata   = alu_res;
        instr_done = 1'b0;
        halted     = 1'b0;
        req_int    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state)
            FETCH: begin
                req_int  = 1'b1;
                mem_addr = pc;
                if (mem_ready) begin
                    ir_nxt    = mem_rdata;
                    state_nxt = EXEC;
                end
            end

            EXEC: begin
                case (op)
                    // halt retires too, but leaves PC where it is
                    OP_HALT: begin
                        instr_done = 1'b1;
                        state_nxt  = HALT;
                    end
                    OP_LOADR, OP_STORER: begin
                        state_nxt = MEM;
                    end
                    default: begin
                        instr_done = 1'b1;
                        rf_we      = writes_rx(op);
                        pc_nxt     = pc_exec;
                        state_nxt  = FETCH;
                    end
                endcase
            end

            MEM: begin
                req_int   = 1'b1;
                mem_we    = (op == OP_STORER);
                mem_addr  = ADDR_W'(rd_a);
                mem_wdata = rd_b;
                if (mem_ready) begin
                    rf_we      = (op == OP_LOADR);
                    rf_wdata   = mem_rdata[DATA_W-1:0];
                    instr_done = 1'b1;
                    pc_nxt     = pc_inc;
                    state_nxt  = FETCH;
                end
            end

            HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // The request is masked by reset directly so it drops the moment reset
    // asserts, even mid-transaction, rather than waiting for a clock edge.
    assign mem_req = req_int & reset;

    // Architectural state: FSM, program counter, instruction register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

endmodule

// File: tb/tb_hmmm_core.sv
// Directed bench for hmmm_core: one 8-bit/8-bit instance with a stallable
// memory model and one 16-bit/10-bit instance with a zero-wait memory.
module tb_hmmm_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- 8-bit instance ----------------
    logic        rst8 = 1'b0;
    logic        req8, we8, done8, halted8;
    logic [7:0]  addr8, wdata8;
    logic [15:0] rdata8;
    logic        ready8 = 1'b1;

    logic [15:0] mem8 [256];
    int          flog8 [64];
    int          fcnt8, wcnt8;
    logic        ldp8;
    int          stall_wr = 0;
    int          wait_cnt = 0;

    hmmm_core #(.DATA_W(8), .ADDR_W(8), .NREGS(8)) dut8 (
        .clk        (clk),
        .reset      (rst8),
        .mem_req    (req8),
        .mem_we     (we8),
        .mem_addr   (addr8),
        .mem_wdata  (wdata8),
        .mem_rdata  (rdata8),
        .mem_ready  (ready8),
        .instr_done (done8),
        .halted     (halted8)
    );

    assign rdata8 = mem8[addr8];

    // Stores are held off for stall_wr cycles; everything else is zero-wait.
    always @(negedge clk) begin
        if (req8 && we8) begin
            if (wait_cnt < stall_wr) begin
                ready8   <= 1'b0;
                wait_cnt <= wait_cnt + 1;
            end else begin
                ready8 <= 1'b1;
            end
        end else begin
            ready8   <= 1'b1;
            wait_cnt <= 0;
        end
    end

    // Memory writes plus a log of instruction fetch addresses.
    always @(posedge clk) begin
        if (!rst8) begin
            fcnt8 <= 0;
            wcnt8 <= 0;
            ldp8  <= 1'b0;
        end else if (req8 && ready8) begin
            if (we8) begin
                mem8[addr8] <= {8'h00, wdata8};
                wcnt8       <= wcnt8 + 1;
            end else if (ldp8) begin
                ldp8 <= 1'b0;
            end else begin
                if (fcnt8 < 64) flog8[fcnt8] <= int'(addr8);
                fcnt8 <= fcnt8 + 1;
                ldp8  <= (rdata8[15:12] == 4'h2);
            end
        end
    end

    // ---------------- 16-bit instance ----------------
    logic        rst16 = 1'b0;
    logic        req16, we16, done16, halted16;
    logic [9:0]  addr16;
    logic [15:0] wdata16, rdata16;
    logic        ready16 = 1'b1;

    logic [15:0] mem16 [1024];
    int          flog16 [1024];
    int          fcnt16, dcnt16;
    logic        ldp16;

    hmmm_core #(.DATA_W(16), .ADDR_W(10), .NREGS(8)) dut16 (
        .clk        (clk),
        .reset      (rst16),
        .mem_req    (req16),
        .mem_we     (we16),
        .mem_addr   (addr16),
        .mem_wdata  (wdata16),
        .mem_rdata  (rdata16),
        .mem_ready  (ready16),
        .instr_done (done16),
        .halted     (halted16)
    );

    assign rdata16 = mem16[addr16];

    always @(posedge clk) begin
        if (!rst16) begin
            fcnt16 <= 0;
            dcnt16 <= 0;
            ldp16  <= 1'b0;
        end else begin
            if (done16) dcnt16 <= dcnt16 + 1;
            if (req16 && ready16) begin
                if (we16) begin
                    mem16[addr16] <= wdata16;
                end else if (ldp16) begin
                    ldp16 <= 1'b0;
                end else begin
                    if (fcnt16 < 1024) flog16[fcnt16] <= int'(addr16);
                    fcnt16 <= fcnt16 + 1;
                    ldp16  <= (rdata16[15:12] == 4'h2);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem8();
        for (int i = 0; i < 256; i++) mem8[i] = 16'hF000;
    endtask

    task automatic reset8();
        rst8 = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
    endtask

    task automatic run8(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (!halted8 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_halted"}, halted8, 1);
    endtask

    task automatic check_flog8(input string tag, input int exp[$]);
        check_val({tag, "_nfetch"}, fcnt8, exp.size());
        for (int i = 0; i < exp.size() && i < 64; i++)
            check_val($sformatf("%s_fetch%0d", tag, i), flog8[i], exp[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int q[$];
        int pulses;
        int n;

        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int q[$];
        int pulses;
        int n;

        // ---- program A: setn r1,5; setn r2,-3; add r3,r1,r2; halt ----
        clear_mem8();
        mem8[0] = 16'h1105;
        mem8[1] = 16'h12FD;
        mem8[2] = 16'h4312;
        mem8[3] = 16'h0000;
        repeat (3) @(negedge clk);
        check_val("rst_req",    req8,    0);
        check_val("rst_we",     we8,     0);
        check_val("rst_addr",   addr8,   0);
        check_val("rst_wdata",  wdata8,  0);
        check_val("rst_done",   done8,   0);
        check_val("rst_halted", halted8, 0);
        rst8 = 1'b1;
        #1;
        check_val("first_req",  req8,  1);
        check_val("first_addr", addr8, 0);
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            if (done8) pulses++;
            if (k == 8) check_val("a_halted_cyc8", halted8, 0);
            @(negedge clk);
        end
        check_val("a_halted_after8", halted8, 1);
        check_val("a_done_pulses",   pulses,  4);
        check_val("a_halt_noreq",    req8,    0);

        // ---- program B: ALU results stored out, load, branches ----
        rst8 = 1'b0;
        clear_mem8();
        mem8[0]  = 16'h1105;  mem8[1]  = 16'h12FD;  mem8[2]  = 16'h4312;
        mem8[3]  = 16'h1480;  mem8[4]  = 16'h3340;  mem8[5]  = 16'h1113;
        mem8[6]  = 16'h1211;  mem8[7]  = 16'h6312;  mem8[8]  = 16'h7401;
        mem8[9]  = 16'h3340;  mem8[10] = 16'h1100;  mem8[11] = 16'h1201;
        mem8[12] = 16'h5312;  mem8[13] = 16'h7401;  mem8[14] = 16'h3340;
        mem8[15] = 16'h1007;  mem8[16] = 16'h4500;  mem8[17] = 16'h7401;
        mem8[18] = 16'h3540;  mem8[19] = 16'h1790;  mem8[20] = 16'h2670;
        mem8[21] = 16'h7401;  mem8[22] = 16'h3640;  mem8[23] = 16'h1180;
        mem8[24] = 16'hD120;  mem8[25] = 16'h0000;
        mem8[8'h20] = 16'h1100;  mem8[8'h21] = 16'hC140;  mem8[8'h22] = 16'hB150;
        mem8[8'h23] = 16'h1201;  mem8[8'h24] = 16'hC228;  mem8[8'h25] = 16'h0000;
        mem8[8'h28] = 16'hA130;  mem8[8'h30] = 16'h1738;  mem8[8'h31] = 16'h9700;
        mem8[8'h38] = 16'h0000;
        for (int i = 8'h80; i <= 8'h84; i++) mem8[i] = 16'h5A5A;
        mem8[8'h90] = 16'h1234;
        reset8();
        run8("b", 400);
        check_val("b_add_r3",    mem8[8'h80], 16'h0002);
        check_val("b_mul_r3",    mem8[8'h81], 16'h0043);
        check_val("b_sub_r3",    mem8[8'h82], 16'h00FF);
        check_val("b_r0_zero",   mem8[8'h83], 16'h0000);
        check_val("b_load_r6",   mem8[8'h84], 16'h0034);
        check_val("b_writes",    wcnt8,       5);
        q = {};
        for (int i = 0; i <= 24; i++) q.push_back(i);
        q.push_back(32'h20); q.push_back(32'h21); q.push_back(32'h22);
        q.push_back(32'h23); q.push_back(32'h24); q.push_back(32'h28);
        q.push_back(32'h30); q.push_back(32'h31); q.push_back(32'h38);
        check_flog8("b", q);

        // ---- program C: jumpn, calln r5 at 0x10, calln r0 ----
        rst8 = 1'b0;
        clear_mem8();
        mem8[0]     = 16'h8010;
        mem8[8'h10] = 16'hE530;
        mem8[8'h30] = 16'h1480;  mem8[8'h31] = 16'h3540;  mem8[8'h32] = 16'hE040;
        mem8[8'h40] = 16'h7401;  mem8[8'h41] = 16'h3040;  mem8[8'h42] = 16'h0000;
        mem8[8'h80] = 16'h5A5A;  mem8[8'h81] = 16'h5A5A;
        reset8();
        run8("c", 100);
        check_val("c_call_link", mem8[8'h80], 16'h0011);
        check_val("c_r0_after_call", mem8[8'h81], 16'h0000);
        q = {};
        q.push_back(0);     q.push_back(32'h10); q.push_back(32'h30); q.push_back(32'h31);
        q.push_back(32'h32); q.push_back(32'h40); q.push_back(32'h41); q.push_back(32'h42);
        check_flog8("c", q);

        // ---- program D: storer r1,r2 with 3 stall cycles ----
        rst8 = 1'b0;
        clear_mem8();
        mem8[0] = 16'h11AA;  mem8[1] = 16'h1240;  mem8[2] = 16'h3120;  mem8[3] = 16'h0000;
        mem8[8'h40] = 16'h5A5A;
        stall_wr = 3;
        reset8();
        n = 0;
        while (!(req8 && we8) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("d_store_seen", req8 & we8, 1);
        n = 0;
        while (req8 && we8 && n < 20) begin
            check_val($sformatf("d_addr_c%0d", n),  addr8,  8'h40);
            check_val($sformatf("d_wdata_c%0d", n), wdata8, 8'hAA);
            n++;
            @(negedge clk);
        end
        check_val("d_req_cycles", n, 4);
        run8("d", 50);
        check_val("d_write_count", wcnt8, 1);
        check_val("d_mem",         mem8[8'h40], 16'h00AA);

        // ---- program E: reset while a store is pending ----
        rst8 = 1'b0;
        mem8[8'h40] = 16'h5A5A;
        stall_wr = 50;
        reset8();
        n = 0;
        while (!(req8 && we8) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("e_store_seen", req8 & we8, 1);
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        #1;
        check_val("e_req_dropped", req8, 0);
        repeat (3) @(negedge clk);
        check_val("e_no_write", mem8[8'h40], 16'h5A5A);
        stall_wr = 0;
        rst8 = 1'b1;
        #1;
        check_val("e_refetch_req",  req8,  1);
        check_val("e_refetch_addr", addr8, 0);
        check_val("e_refetch_we",   we8,   0);
        run8("e", 50);
        check_val("e_mem_after", mem8[8'h40], 16'h00AA);

        // ---- program F: 16/10 PC wrap via increment ----
        for (int i = 0; i < 1024; i++) mem16[i] = 16'hF000;
        mem16[0] = 16'h80FF;
        @(negedge clk);
        rst16 = 1'b1;
        n = 0;
        while (fcnt16 < 772 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        rst16 = 1'b0;
        check_val("f_fetches",   fcnt16 >= 772, 1);
        check_val("f_fetch0",    flog16[0],   0);
        check_val("f_jump_ff",   flog16[1],   32'h0FF);
        check_val("f_inc_100",   flog16[2],   32'h100);
        check_val("f_top_3ff",   flog16[769], 32'h3FF);
        check_val("f_wrap_000",  flog16[770], 32'h000);
        check_val("f_again_0ff", flog16[771], 32'h0FF);

        // ---- program G: 16-bit loadr and sign-extended setn ----
        for (int i = 0; i < 1024; i++) mem16[i] = 16'hF000;
        mem16[0] = 16'h1150;  mem16[1] = 16'h2210;  mem16[2] = 16'h1360;
        mem16[3] = 16'h3230;  mem16[4] = 16'h14F0;  mem16[5] = 16'h7301;
        mem16[6] = 16'h3430;  mem16[7] = 16'h0000;
        mem16[10'h50] = 16'hBEEF;
        mem16[10'h60] = 16'h5A5A;
        mem16[10'h61] = 16'h5A5A;
        repeat (2) @(negedge clk);
        rst16 = 1'b1;
        n = 0;
        while (!halted16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("g_halted",   halted16,      1);
        check_val("g_load16",   mem16[10'h60], 16'hBEEF);
        check_val("g_setn_neg", mem16[10'h61], 16'hFFF0);
        check_val("g_done_cnt", dcnt16,        8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
